rvseed_ifu: RTL

Instruction fetch unit of the rvseed core, directly upstream of the IF/ID pipeline register.
- Generates the fetch PC and runs a req/gnt/rvalid handshake to instruction memory, one request outstanding at a time.
- Presents each returned instruction with its PC as a one-cycle valid pulse (ifu2idu_en/pc/inst).
- Handles decode-stage stall and branch/jump redirect, dropping stale responses.

---
 rtl/rvseed_ifu_pkg.sv | 16 +
 rtl/rvseed_ifu_if.sv | 28 ++
 rtl/rvseed_ifu_skid_buf.sv | 42 ++++
 rtl/rvseed_ifu.sv | 138 +++++++++++++
 4 files changed

// File: rtl/rvseed_ifu_pkg.sv
// rtl/rvseed_ifu_pkg.sv - shared widths, reset PC, NOP encoding and IFU state type
package rvseed_ifu_pkg;

  localparam int unsigned RV_CPU_WIDTH  = 32;
  localparam logic [31:0] RV_RESET_PC   = 32'h0000_0000;
  localparam int unsigned RV_INST_BYTES = 4;
  localparam logic [31:0] RV_NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/rvseed_ifu_if.sv
// rtl/rvseed_ifu_if.sv - fetch bus: imem req/gnt/rvalid, decode stall/redirect, IF/ID delivery
interface rvseed_ifu_if #(
  parameter int unsigned CPU_WIDTH = 32
);

  logic                 imem_req;
  logic [CPU_WIDTH-1:0] imem_addr;
  logic                 imem_gnt;
  logic                 imem_rvalid;
  logic [CPU_WIDTH-1:0] imem_rdata;
  logic                 stall;
  logic                 redirect_en;
  logic [CPU_WIDTH-1:0] redirect_pc;
  logic                 ifu2idu_en;
  logic [CPU_WIDTH-1:0] ifu2idu_pc;
  logic [CPU_WIDTH-1:0] ifu2idu_inst;

  modport master (
    output imem_req, imem_addr, ifu2idu_en, ifu2idu_pc, ifu2idu_inst,
    input  imem_gnt, imem_rvalid, imem_rdata, stall, redirect_en, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, ifu2idu_en, ifu2idu_pc, ifu2idu_inst,
    output imem_gnt, imem_rvalid, imem_rdata, stall, redirect_en, redirect_pc
  );

endinterface

// File: rtl/rvseed_ifu_skid_buf.sv
// rtl/rvseed_ifu_skid_buf.sv - one-entry {pc, inst} buffer holding a response while decode stalls
module rvseed_ifu_skid_buf #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr,
  input  logic         i_rd,
  input  logic         i_flush,
  input  logic [W-1:0] i_wr_pc,
  input  logic [W-1:0] i_wr_inst,
  output logic         o_full,
  output logic [W-1:0] o_pc,
  output logic [W-1:0] o_inst
);

  logic         r_full;
  logic [W-1:0] r_pc;
  logic [W-1:0] r_inst;

  // flush beats write beats read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_pc   <= '0;
      r_inst <= '0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_wr) begin
      r_full <= 1'b1;
      r_pc   <= i_wr_pc;
      r_inst <= i_wr_inst;
    end else if (i_rd) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_pc   = r_pc;
  assign o_inst = r_inst;

endmodule

// File: rtl/rvseed_ifu.sv
// rtl/rvseed_ifu.sv - rvseed instruction fetch unit, one imem request outstanding
// RVSEED_IFU_MISALIGN_CHK_EN adds the sticky ifu_misalign_err output and word-aligns redirect targets.
module rvseed_ifu
  import rvseed_ifu_pkg::*;
#(
  parameter int unsigned          CPU_WIDTH  = RV_CPU_WIDTH,
  parameter logic [CPU_WIDTH-1:0] RESET_PC   = RV_RESET_PC,
  parameter int unsigned          INST_BYTES = RV_INST_BYTES
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef RVSEED_IFU_MISALIGN_CHK_EN
  output logic         ifu_misalign_err,
`endif
  rvseed_ifu_if.master bus
);

  ifu_state_e           r_state, w_state_nxt;
  logic [CPU_WIDTH-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [CPU_WIDTH-1:0] r_req_pc, w_req_pc_nxt;
  logic [CPU_WIDTH-1:0] r_last_pc, r_last_inst;
  logic [CPU_WIDTH-1:0] w_redir_pc, w_src_pc, w_src_inst, w_buf_pc, w_buf_inst;
  logic                 r_kill, w_kill_nxt;
  logic                 w_buf_wr, w_buf_rd, w_buf_full, w_live, w_en;

`ifdef RVSEED_IFU_MISALIGN_CHK_EN
  logic r_misalign_err;

  assign w_redir_pc = {bus.redirect_pc[CPU_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_misalign_err <= 1'b0;
    else if (bus.redirect_en && (bus.redirect_pc[1:0] != 2'b00))
      r_misalign_err <= 1'b1;
  end

  assign ifu_misalign_err = r_misalign_err;
`else
  assign w_redir_pc = bus.redirect_pc;
`endif

  // a response is live only if no redirect happened since its request was granted
  assign w_live     = (r_state == ST_WAIT) && bus.imem_rvalid && !r_kill;
  assign w_en       = !bus.redirect_en && !bus.stall && (w_buf_full || w_live);
  assign w_src_pc   = w_buf_full ? w_buf_pc   : r_req_pc;
  assign w_src_inst = w_buf_full ? w_buf_inst : bus.imem_rdata;
  assign w_buf_rd   = w_en && w_buf_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_pc_nxt   = r_req_pc;
    w_kill_nxt     = r_kill;
    w_buf_wr       = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (bus.imem_gnt) begin
          w_req_pc_nxt   = r_fetch_pc;
          w_fetch_pc_nxt = r_fetch_pc + CPU_WIDTH'(INST_BYTES);
          w_state_nxt    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          w_kill_nxt  = 1'b0;
          w_buf_wr    = w_live && bus.stall && !bus.redirect_en;
          w_state_nxt = w_buf_wr ? ST_HOLD : ST_REQ;
        end
      end
      ST_HOLD: begin
        if (!bus.stall)
          w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // redirect overrides; a request already granted but not yet answered must be killed
    if (bus.redirect_en) begin
      w_fetch_pc_nxt = w_redir_pc;
      if (((r_state == ST_REQ) && bus.imem_gnt) ||
          ((r_state == ST_WAIT) && !bus.imem_rvalid)) begin
        w_kill_nxt  = 1'b1;
        w_state_nxt = ST_WAIT;
      end else begin
        w_state_nxt = ST_REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc  <= RESET_PC;
      r_req_pc    <= RESET_PC;
      r_kill      <= 1'b0;
      r_last_pc   <= RESET_PC;
      r_last_inst <= CPU_WIDTH'(RV_NOP);
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_kill     <= w_kill_nxt;
      if (w_en) begin
        r_last_pc   <= w_src_pc;
        r_last_inst <= w_src_inst;
      end
    end
  end

  rvseed_ifu_skid_buf #(
    .W (CPU_WIDTH)
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr      (w_buf_wr),
    .i_rd      (w_buf_rd),
    .i_flush   (bus.redirect_en),
    .i_wr_pc   (r_req_pc),
    .i_wr_inst (bus.imem_rdata),
    .o_full    (w_buf_full),
    .o_pc      (w_buf_pc),
    .o_inst    (w_buf_inst)
  );

  assign bus.imem_req     = (r_state == ST_REQ);
  assign bus.imem_addr    = r_fetch_pc;
  assign bus.ifu2idu_en   = w_en;
  assign bus.ifu2idu_pc   = w_en ? w_src_pc   : r_last_pc;
  assign bus.ifu2idu_inst = w_en ? w_src_inst : r_last_inst;

endmodule
